cpu_state_vec_loader: RTL
=========================

Name: cpu_state_vec_loader

Overview:
- Loads one flattened CPU state vector (the STATE_W-bit input bus consumed by the cluster output-bit evaluators) from a narrow word stream.
- Assembles the vector chunk by chunk and presents it in full, with a valid/ready handshake, to the evaluator cluster.
- Sits between the trace/stimulus source and the combinational output-bit modules, and feeds them exactly one complete state per frame.

Parameters:
- STATE_W, 1894, width of the assembled state vector.
- WORD_W, 32, width of each incoming chunk.
- CNT_W, 16, width of the completed-frame counter.
- NCHUNK (local), ceil(STATE_W/WORD_W), number of chunks per frame. Value is 60 at the defaults.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- s_valid  input  1  the input word is valid.
- s_ready  output  1  the loader accepts a word this cycle.
- s_data  input  WORD_W  state chunk.
- s_last  input  1  marks the final chunk of a frame.
- m_valid  output  1  m_vec holds a complete state.
- m_ready  input  1  the evaluator cluster consumes m_vec.
- m_vec  output  STATE_W  assembled state vector; bit n is state bit i[n].
- frame_err  output  1  one-cycle pulse when a frame is malformed.
- frame_cnt  output  CNT_W  count of frames delivered; wraps modulo 2^CNT_W.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state LOAD, chunk index 0, m_vec all zeros, m_valid 0, s_ready 1, frame_err 0, frame_cnt 0.
- Reset mid-frame discards all partial data immediately.
- A word is accepted when s_valid and s_ready are both high at a rising edge.
- FSM states: LOAD, DRAIN, PRESENT.
- LOAD: s_ready=1, m_valid=0.
  - An accepted word at index k writes m_vec[k*WORD_W +: WORD_W]. The final chunk is truncated to its STATE_W-(NCHUNK-1)*WORD_W low bits; its upper bits are ignored.
  - k<NCHUNK-1 and s_last=0: k increments.
  - k=NCHUNK-1 and s_last=1: go to PRESENT next cycle and reset k to 0.
  - k<NCHUNK-1 and s_last=1 (early last): pulse frame_err for one cycle, reset k to 0, stay in LOAD. The next word is chunk 0.
  - k=NCHUNK-1 and s_last=0 (missing last): pulse frame_err for one cycle, reset k to 0, go to DRAIN.
- DRAIN: s_ready=1, m_valid=0. Accepted words are discarded. An accepted word with s_last=1 returns the FSM to LOAD with k=0. No further frame_err pulses occur in DRAIN.
- PRESENT: m_valid=1, s_ready=0, m_vec held stable.
  - On m_valid and m_ready: go to LOAD next cycle and increment frame_cnt by 1, wrapping.
  - m_valid never deasserts before m_ready is seen.
- Latency: m_valid rises the cycle after the last chunk is accepted. Minimum frame period is NCHUNK+1 cycles.
- m_vec holds the last value after delivery. A new frame overwrites it chunk by chunk; consumers must sample only while m_valid=1.
- Idle cycles between accepted words are allowed with no limit and do not change the result.
- s_data and s_last are don't-care when s_valid=0.
- No combinational path from s_valid to s_ready, or from m_ready to m_valid.

Test Plan:
- Normal frame at defaults: 60 back-to-back words, word k = k, s_last on word 59 -> m_valid rises on cycle 61. m_vec[31:0]=0, m_vec[63:32]=1, m_vec[1893:1888]=6'b111011. With m_ready=1, frame_cnt=1 and s_ready=1 on the following cycle.
- Backpressure: complete a frame with m_ready=0 for 10 cycles -> m_valid stays 1, s_ready stays 0, m_vec unchanged. Raising m_ready gives one transfer and frame_cnt increments by exactly 1.
- Early last: s_last on word 10 -> frame_err=1 for one cycle, no m_valid. A following well-formed 60-word frame with word k = 0x100+k is delivered correctly, so m_vec[31:0]=0x100.
- Missing last: 60 words with no s_last, then 5 more words with s_last on the 5th -> frame_err pulses once at word 59 and all 5 words are dropped. The next good frame is delivered and frame_cnt counts only good frames.
- Reset mid-frame: assert rst after 30 accepted words -> m_vec=0, m_valid=0, frame_cnt=0 immediately. A following full frame produces the same result as the normal-frame case.
- Random s_valid gaps (0-5 idle cycles between words) with frame_cnt preset near wrap (65535 good frames) -> data identical to the normal-frame case, and frame_cnt wraps to 0.

Source files
------------

// File: rtl/cpu_state_vec_loader.sv
// ---------------------------------------------------------------------------
// cpu_state_vec_loader
//
// Purpose:
//   Assembles one flattened CPU state vector (STATE_W bits) from a narrow
//   word stream and presents it, with a valid/ready handshake, to the
//   evaluator cluster. Exactly one complete state is delivered per frame.
//   Malformed frames (early or missing s_last) raise a one-cycle frame_err
//   pulse. A frame that runs past NCHUNK words without s_last is drained
//   up to and including its s_last word.
//
// Ports:
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high
//   s_valid    in   1        input word valid
//   s_ready    out  1        loader accepts a word this cycle
//   s_data     in   WORD_W   state chunk
//   s_last     in   1        final chunk of a frame
//   m_valid    out  1        m_vec holds a complete state
//   m_ready    in   1        evaluator cluster consumes m_vec
//   m_vec      out  STATE_W  assembled state vector
//   frame_err  out  1        one-cycle pulse on a malformed frame
//   frame_cnt  out  CNT_W    delivered-frame count, wraps
// ---------------------------------------------------------------------------
module cpu_state_vec_loader #(
    parameter int STATE_W = 1894,
    parameter int WORD_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               s_valid,
    output logic               s_ready,
    input  logic [WORD_W-1:0]  s_data,
    input  logic               s_last,
    output logic               m_valid,
    input  logic               m_ready,
    output logic [STATE_W-1:0] m_vec,
    output logic               frame_err,
    output logic [CNT_W-1:0]   frame_cnt
);

    localparam int NCHUNK = (STATE_W + WORD_W - 1) / WORD_W;
    // Width of the final, possibly partial, chunk.
    localparam int LAST_W = STATE_W - (NCHUNK - 1) * WORD_W;
    localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_LOAD    = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_PRESENT = 2'd2
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   idx_q;
    logic               s_ready_q;
    logic               m_valid_q;
    logic               frame_err_q;
    logic [CNT_W-1:0]   frame_cnt_q;
    logic [STATE_W-1:0] vec_q;

    // A word lands in the vector only while loading; drained words are dropped.
    logic load_acc_s;
    assign load_acc_s = s_valid & s_ready_q & (state_q == ST_LOAD);

    // Frame-control FSM: chunk index, handshake flags, error pulse, frame counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            idx_q       <= '0;
            s_ready_q   <= 1'b1;
            m_valid_q   <= 1'b0;
            frame_err_q <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                ST_LOAD: begin
                    if (s_valid) begin
                        if (idx_q == LAST_IDX) begin
                            idx_q <= '0;
                            if (s_last) begin
                                state_q   <= ST_PRESENT;
                                s_ready_q <= 1'b0;
                                m_valid_q <= 1'b1;
                            end else begin
                                // Missing last: swallow the rest of this frame.
                                state_q     <= ST_DRAIN;
                                frame_err_q <= 1'b1;
                            end
                        end else if (s_last) begin
                            // Early last: restart so the next word is chunk 0.
                            idx_q       <= '0;
                            frame_err_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
                        end
                    end
                end
                ST_DRAIN: begin
                    if (s_valid && s_last) begin
                        state_q <= ST_LOAD;
                        idx_q   <= '0;
                    end
                end
                ST_PRESENT: begin
                    if (m_ready) begin
                        state_q     <= ST_LOAD;
                        s_ready_q   <= 1'b1;
                        m_valid_q   <= 1'b0;
                        frame_cnt_q <= frame_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                    end
                end
                default: begin
                    state_q   <= ST_LOAD;
                    idx_q     <= '0;
                    s_ready_q <= 1'b1;
                    m_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Vector assembly: the accepted word overwrites the chunk selected by idx_q.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vec_q <= '0;
        end else if (load_acc_s) begin
            for (int c = 0; c < NCHUNK - 1; c++) begin
                if (idx_q == IDX_W'(c)) begin
                    vec_q[c*WORD_W +: WORD_W] <= s_data;
                end
            end
            // The final chunk keeps only its low LAST_W bits.
            if (idx_q == LAST_IDX) begin
                vec_q[STATE_W-1 -: LAST_W] <= s_data[LAST_W-1:0];
            end
        end
    end

    assign s_ready   = s_ready_q;
    assign m_valid   = m_valid_q;
    assign m_vec     = vec_q;
    assign frame_err = frame_err_q;
    assign frame_cnt = frame_cnt_q;

endmodule
